layer_sequencer: RTL and testbench



---
 rtl/nn_pkg.sv | 20 ++
 rtl/mac_sat_unit.sv | 79 +++++++
 rtl/layer_sequencer.sv | 142 ++++++++++++++
 tb/tb_layer_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-network layer datapath.
package nn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 15;
  localparam int ACC_WIDTH  = 40;

  // Q1.15 saturation limits
  localparam logic [DATA_WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } layer_state_t;

endpackage

// File: rtl/mac_sat_unit.sv
// Shared MAC datapath: multiply, accumulate, bias add, Q1.15 conversion with
// saturation and optional ReLU. Holds no sequencing logic of its own.
module mac_sat_unit
  import nn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  input  logic                  bias_ld,
  input  logic                  relu,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [DATA_WIDTH-1:0] result
);

  // One extra bit so the bias add itself can never wrap
  localparam int SUM_WIDTH = ACC_WIDTH + 1;
  localparam int SHR_WIDTH = SUM_WIDTH - FRAC_BITS;
  localparam logic signed [SHR_WIDTH-1:0] MAX_VAL = SHR_WIDTH'(32767);
  localparam logic signed [SHR_WIDTH-1:0] MIN_VAL = SHR_WIDTH'(-32768);

  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]   bias_q;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext;
  logic signed [SUM_WIDTH-1:0]    acc_ext;
  logic signed [SUM_WIDTH-1:0]    bias_ext;
  logic signed [SUM_WIDTH-1:0]    sum;
  logic signed [SHR_WIDTH-1:0]    shifted;

  assign product     = $signed(in_data) * $signed(w_data);
  assign product_ext = {{(ACC_WIDTH-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};

  // Next accumulator value: clear wins over accumulate
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + product_ext;
    end
  end

  // Accumulator and captured bias registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      bias_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (bias_ld) begin
        bias_q <= $signed(b_data);
      end
    end
  end

  // Bias is aligned to Q2.30 by appending FRAC_BITS zeros; dropping the low
  // FRAC_BITS of the sum is an arithmetic shift that truncates toward -inf.
  assign acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
  assign bias_ext = {{(SUM_WIDTH-DATA_WIDTH-FRAC_BITS){bias_q[DATA_WIDTH-1]}},
                     bias_q, {FRAC_BITS{1'b0}}};
  assign sum      = acc_ext + bias_ext;
  assign shifted  = sum[SUM_WIDTH-1:FRAC_BITS];

  // Saturate to Q1.15, then clamp negatives to zero when ReLU is selected
  always_comb begin
    result = shifted[DATA_WIDTH-1:0];
    if (relu && shifted[SHR_WIDTH-1]) begin
      result = '0;
    end else if (shifted > MAX_VAL) begin
      result = SAT_POS;
    end else if (shifted < MIN_VAL) begin
      result = SAT_NEG;
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer: walks input, weight and bias memories for
// each neuron through one shared MAC and writes one saturated result per neuron.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int INPUT_SIZE   = 784,
  parameter int NUM_NEURONS  = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int NEURON_WIDTH = 5,
  parameter int WADDR_WIDTH  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    relu_en,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [WADDR_WIDTH-1:0]  w_addr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  output logic [NEURON_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    out_we,
  output logic [NEURON_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]   out_data
);

  localparam logic [ADDR_WIDTH-1:0]   K_LAST = ADDR_WIDTH'(INPUT_SIZE - 1);
  localparam logic [NEURON_WIDTH-1:0] N_LAST = NEURON_WIDTH'(NUM_NEURONS - 1);

  layer_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   k_q, k_d;
  logic [NEURON_WIDTH-1:0] n_q, n_d;
  logic [WADDR_WIDTH-1:0]  w_q, w_d;
  logic                    relu_q, relu_d;
  logic                    acc_en, acc_clr, bias_ld;
  logic [DATA_WIDTH-1:0]   sat_result;

  // State, counters and latched ReLU select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      w_q     <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      w_q     <= w_d;
      relu_q  <= relu_d;
    end
  end

  // Next-state, counter updates and datapath controls. The weight address is
  // kept as a running counter (n*INPUT_SIZE+k) so no multiplier is needed.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    w_d     = w_q;
    relu_d  = relu_q;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    bias_ld = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    out_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          relu_d  = relu_en;
          k_d     = '0;
          n_d     = '0;
          w_d     = '0;
          acc_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        busy   = 1'b1;
        // Data returned now belongs to the previous cycle's address, which
        // only exists once k has moved past the first term of this neuron.
        acc_en = (k_q != '0);
        if (k_q == K_LAST) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
          w_d = w_q + 1'b1;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        acc_en  = 1'b1;
        bias_ld = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        out_we  = 1'b1;
        acc_clr = 1'b1;
        k_d     = '0;
        if (n_q == N_LAST) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + 1'b1;
          w_d     = w_q + 1'b1;
          state_d = MAC;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  mac_sat_unit u_mac (
    .clk     (clk),
    .rst     (rst),
    .acc_en  (acc_en),
    .acc_clr (acc_clr),
    .bias_ld (bias_ld),
    .relu    (relu_q),
    .in_data (in_data),
    .w_data  (w_data),
    .b_data  (b_data),
    .result  (sat_result)
  );

  assign in_addr  = k_q;
  assign w_addr   = w_q;
  assign b_addr   = n_q;
  assign out_addr = n_q;
  assign out_data = out_we ? sat_result : '0;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer with small parameters and 1-cycle ROMs.
module tb_layer_sequencer;

  localparam int IS      = 4;
  localparam int NN      = 2;
  localparam int AW      = 3;
  localparam int NW      = 2;
  localparam int WW      = 4;
  localparam int RUN_LEN = NN * (IS + 2) + 1;  // cycle index of the done pulse

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          relu_en = 1'b0;
  logic          busy, done, out_we;
  logic [AW-1:0] in_addr;
  logic [WW-1:0] w_addr;
  logic [NW-1:0] b_addr, out_addr;
  logic [15:0]   in_data, w_data, b_data, out_data;

  logic [15:0] in_mem [0:IS-1];
  logic [15:0] w_mem  [0:NN*IS-1];
  logic [15:0] b_mem  [0:NN-1];

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  layer_sequencer #(
    .INPUT_SIZE  (IS),
    .NUM_NEURONS (NN),
    .ADDR_WIDTH  (AW),
    .NEURON_WIDTH(NW),
    .WADDR_WIDTH (WW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .relu_en  (relu_en),
    .busy     (busy),
    .done     (done),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .out_we   (out_we),
    .out_addr (out_addr),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle-latency ROM models
  always @(posedge clk) begin
    in_data <= (int'(in_addr) < IS) ? in_mem[in_addr] : 16'hDEAD;
    w_data  <= (int'(w_addr) < NN*IS) ? w_mem[w_addr] : 16'hDEAD;
    b_data  <= (int'(b_addr) < NN) ? b_mem[b_addr] : 16'hDEAD;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact dot product, floor division by 2^15, clamp, ReLU
  function automatic int expect_out(input int n, input bit relu);
    longint s = 0;
    longint q;
    for (int k = 0; k < IS; k++) begin
      s += longint'($signed(in_mem[k])) * longint'($signed(w_mem[n*IS+k]));
    end
    s += longint'($signed(b_mem[n])) * 32768;
    q = s / 32768;
    if (s < 0 && (s % 32768) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    if (relu && q < 0) q = 0;
    return int'(q) & 16'hFFFF;
  endfunction

  // Monitor: pops expected writes / done pulses whenever the DUT presents one
  always @(negedge clk) begin : monitor
    wr_t e;
    int  dc;
    if (!rst) begin
      if (out_we) begin
        $display("write addr=%0d data=%04h cyc=%0d", out_addr, out_data, cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0d data %04h expected no write", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_addr", int'(out_addr), e.addr);
          check("out_data", int'(out_data), e.data);
          check("write_cycle", cyc, e.cyc);
          check("busy_in_write", int'(busy), 1);
        end
      end
      if (done) begin
        $display("done cyc=%0d", cyc);
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          dc = done_q.pop_front();
          check("done_cycle", cyc, dc);
          check("busy_in_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic fill(input logic [15:0] iv, input logic [15:0] w0,
                      input logic [15:0] w1, input logic [15:0] bv);
    for (int k = 0; k < IS; k++) begin
      in_mem[k]     = iv;
      w_mem[k]      = w0;
      w_mem[IS + k] = w1;
    end
    for (int n = 0; n < NN; n++) b_mem[n] = bv;
  endtask

  task automatic fill_random();
    for (int k = 0; k < IS; k++) in_mem[k] = 16'($urandom);
    for (int k = 0; k < NN*IS; k++) w_mem[k] = 16'($urandom);
    for (int n = 0; n < NN; n++) b_mem[n] = 16'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_out_we"}, int'(out_we), 0);
    check({tag, "_in_addr"}, int'(in_addr), 0);
    check({tag, "_w_addr"}, int'(w_addr), 0);
    check({tag, "_b_addr"}, int'(b_addr), 0);
    check({tag, "_out_addr"}, int'(out_addr), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
  endtask

  // Issue one run; expectations are pushed at issue time. noisy adds ignored
  // start pulses (mid-run and in DONE) and relu_en churn; rst_at>0 resets then.
  task automatic run(input bit relu, input bit noisy, input int rst_at);
    int s;
    int c;
    @(negedge clk);
    relu_en = relu;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s = cyc;
    for (int n = 0; n < NN; n++) begin
      exp_q.push_back('{n, expect_out(n, relu), s + (n + 1) * (IS + 2) - 1});
    end
    done_q.push_back(s + RUN_LEN - 1);
    for (int i = 0; i < RUN_LEN + IS + 8; i++) begin
      @(negedge clk);
      c = cyc - s + 1;
      if (c == 1) check("busy_cycle1", int'(busy), 1);
      if (noisy) begin
        relu_en = 1'($urandom_range(0, 1));
        start   = (c == 3 || c == RUN_LEN);
      end
      if (rst_at != 0 && c == rst_at) begin
        rst = 1'b1;
        #1;
        check_idle_outputs("midrun_rst");
        exp_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        break;
      end
    end
    start = 1'b0;
    if (rst_at == 0) begin
      check("writes_outstanding", exp_q.size(), 0);
      check("done_outstanding", done_q.size(), 0);
    end
  endtask

  initial begin
    fill(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    fill(16'h4000, 16'h4000, 16'h4000, 16'h0000);
    run(1'b0, 1'b0, 0);
    fill(16'h2000, 16'h2000, 16'h2000, 16'hF000);
    run(1'b0, 1'b0, 0);
    fill(16'h4000, 16'h4000, 16'hC000, 16'h0000);
    run(1'b0, 1'b0, 0);
    run(1'b1, 1'b0, 0);
    fill(16'h7FFF, 16'h8000, 16'h8000, 16'h8000);
    run(1'b0, 1'b0, 0);
    fill(16'h4000, 16'h4000, 16'h4000, 16'h0000);
    run(1'b0, 1'b1, 0);
    run(1'b0, 1'b0, 8);
    repeat (10) @(negedge clk);
    run(1'b0, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      fill_random();
      run(1'($urandom_range(0, 1)), 1'b1, 0);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
